// File: rtl/led_display_ctrl_pkg.sv
// Shared definitions for the LED display driver: mode encodings and helpers.
package led_display_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BIN   = 2'b00,
        MODE_BAR   = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    // Number of lit bar LEDs: the value clamped to the number of LEDs available.
    function automatic int unsigned clamp_lit(input int unsigned val, input int unsigned max_n);
        return (val < max_n) ? val : max_n;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Global brightness PWM: free-running counter compared against the duty input.
module led_pwm_gen #(
    parameter int unsigned PWM_W = 4
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic [PWM_W-1:0] bright,
    output logic             pwm_on
);

    logic [PWM_W-1:0] pwm_cnt;

    // Free-running counter; wraps from all-ones back to zero.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // All-ones duty is forced fully on so full brightness never drops a cycle.
    assign pwm_on = (&bright) | (pwm_cnt < bright);

endmodule

// File: rtl/led_display_ctrl.sv
// LED display driver: latches a value and shows it as binary, bar graph or
// blinking binary, plus a stretched press indicator, all under PWM dimming.
module led_display_ctrl
    import led_display_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned LED_N       = 5,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned PWM_W       = 4,
    parameter int unsigned BLINK_DIV   = 13_500_000,
    parameter int unsigned STRETCH_CYC = 2_700_000
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_vld,
    input  logic [MODE_W-1:0] mode,
    input  logic [PWM_W-1:0]  bright,
    input  logic              is_pressed,
    output logic [LED_N:0]    led
);

    localparam int unsigned   BLINK_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned   STRETCH_W   = $clog2(STRETCH_CYC + 1);
    localparam logic [LED_N:0] LED_DARK   = {(LED_N + 1){ACTIVE_LOW != 0}};

    mode_e                  mode_in;
    mode_e                  mode_q;
    logic [DATA_W-1:0]      disp_q;
    logic [BLINK_CNT_W-1:0] blink_cnt;
    logic                   blink_on;
    logic [STRETCH_W-1:0]   stretch_cnt;
    logic                   press_act;
    logic                   pwm_on;
    logic [LED_N-1:0]       bin_pat;
    logic [LED_N-1:0]       bar_pat;
    logic [LED_N-1:0]       pat;
    logic [LED_N:0]         lg;
    int unsigned            lit;

    assign mode_in = mode_e'(mode);

    // Capture register and registered display mode.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_q <= '0;
            mode_q <= MODE_OFF;
        end else begin
            if (data_vld) begin
                disp_q <= data;
            end
            mode_q <= mode_in;
        end
    end

    // Blink timer; entering blink mode restarts it in the lit phase.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if ((mode_in == MODE_BLINK) && (mode_q != MODE_BLINK)) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
        end
    end

    // Press stretch: reload while pressed, count down after release.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stretch_cnt <= '0;
        end else if (is_pressed) begin
            stretch_cnt <= STRETCH_W'(STRETCH_CYC);
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - STRETCH_W'(1);
        end
    end

    assign press_act = is_pressed | (stretch_cnt != '0);

    // Binary pattern: value zero-extended or truncated to the LED count.
    assign bin_pat = LED_N'(disp_q);

    // Bar pattern: the lowest min(value, LED_N) LEDs lit.
    always_comb begin
        bar_pat = '0;
        lit     = clamp_lit(32'(disp_q), LED_N);
        for (int unsigned i = 0; i < LED_N; i++) begin
            bar_pat[i] = (i < lit);
        end
    end

    // Pattern select by registered mode.
    always_comb begin
        pat = '0;
        case (mode_q)
            MODE_BIN:   pat = bin_pat;
            MODE_BAR:   pat = bar_pat;
            MODE_BLINK: pat = blink_on ? bin_pat : '0;
            MODE_OFF:   pat = '0;
            default:    pat = '0;
        endcase
    end

    led_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bright    (bright),
        .pwm_on    (pwm_on)
    );

    assign lg = {press_act, pat} & {(LED_N + 1){pwm_on}};

    // Output register with board polarity applied.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= LED_DARK;
        end else begin
            led <= (ACTIVE_LOW != 0) ? ~lg : lg;
        end
    end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Directed bench for led_display_ctrl with a queue-based expected-value scoreboard.
module tb_led_display_ctrl;

    logic       clk;
    logic       sys_rst_n;
    logic [3:0] data;
    logic       data_vld;
    logic [1:0] mode;
    logic [3:0] bright;
    logic       is_pressed;
    logic [5:0] led;

    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] pc       = 4'd0;
    int         lit_cnt;
    logic [5:0] e;

    localparam logic [1:0] M_BIN   = 2'b00;
    localparam logic [1:0] M_BAR   = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_OFF   = 2'b11;

    led_display_ctrl #(
        .DATA_W      (4),
        .LED_N       (5),
        .ACTIVE_LOW  (1),
        .PWM_W       (4),
        .BLINK_DIV   (4),
        .STRETCH_CYC (3)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .data       (data),
        .data_vld   (data_vld),
        .mode       (mode),
        .bright     (bright),
        .is_pressed (is_pressed),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [5:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [5:0] ev;
        string      t;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed led=%b with no expected entry", led);
        end else begin
            ev = exp_q.pop_front();
            t  = tag_q.pop_front();
            assert (led === ev) else begin
                n_fail++;
                $error("FAIL %s: observed led=%b expected %b", t, led, ev);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (sys_rst_n) pc = pc + 4'd1;
    endtask

    task automatic tick(input string tag, input logic [5:0] val);
        push_exp(tag, val);
        advance();
        pop_check();
    endtask

    task automatic expect_now(input string tag, input logic [5:0] val);
        push_exp(tag, val);
        #0;
        pop_check();
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        data       = 4'h0;
        data_vld   = 1'b0;
        mode       = M_BIN;
        bright     = 4'hF;
        is_pressed = 1'b0;

        // Reset held
        repeat (3) advance();
        expect_now("rst_hold", 6'b111111);

        // Reset release, no strobe
        sys_rst_n = 1'b1;
        pc = 4'd0;
        tick("rst_rel_off", 6'b111111);
        tick("rst_rel_bin", 6'b111111);

        // BIN capture with two-cycle latency
        data = 4'hA; data_vld = 1'b1;
        tick("cap_lat", 6'b111111);
        data_vld = 1'b0;
        tick("bin_A", 6'b110101);
        tick("bin_A_hold", 6'b110101);

        // BAR with simultaneous strobe and mode change
        mode = M_BAR; data = 4'h3; data_vld = 1'b1;
        tick("bar_switch", 6'b110101);
        data_vld = 1'b0;
        tick("bar_3", 6'b111000);
        data = 4'hF; data_vld = 1'b1;
        tick("bar_F_lat", 6'b111000);
        data_vld = 1'b0;
        tick("bar_F_clamp", 6'b100000);
        data = 4'h0; data_vld = 1'b1;
        tick("bar_0_lat", 6'b100000);
        data_vld = 1'b0;
        tick("bar_0", 6'b111111);

        // BLINK entry starts lit, 4 cycles per phase
        mode = M_BLINK; data = 4'h5; data_vld = 1'b1;
        tick("blk_enter", 6'b111111);
        data_vld = 1'b0;
        for (int i = 0; i < 4; i++) tick("blk_lit", 6'b111010);
        tick("blk_dark", 6'b111111);

        // Leave during the dark phase and re-enter: restarts lit
        mode = M_BIN;
        tick("blk_leave", 6'b111111);
        mode = M_BLINK;
        tick("blk_reenter_bin", 6'b111010);
        for (int i = 0; i < 4; i++) tick("blk_restart_lit", 6'b111010);
        tick("blk_restart_dark", 6'b111111);

        // OFF mode
        mode = M_OFF;
        tick("off_enter", 6'b111111);
        tick("off", 6'b111111);

        // Press stretch in OFF mode
        is_pressed = 1'b1;
        tick("prs_on", 6'b011111);
        tick("prs_on", 6'b011111);
        is_pressed = 1'b0;
        for (int i = 0; i < 3; i++) tick("prs_stretch", 6'b011111);
        tick("prs_end", 6'b111111);

        // Re-press two cycles after release reloads the stretch
        is_pressed = 1'b1;
        tick("rp_on", 6'b011111);
        tick("rp_on", 6'b011111);
        is_pressed = 1'b0;
        tick("rp_rel", 6'b011111);
        tick("rp_rel", 6'b011111);
        is_pressed = 1'b1;
        tick("rp_repress", 6'b011111);
        is_pressed = 1'b0;
        for (int i = 0; i < 3; i++) tick("rp_reload", 6'b011111);
        tick("rp_end", 6'b111111);

        // PWM dimming on BIN value 5
        mode = M_BIN;
        tick("pwm_enter", 6'b111111);
        tick("pwm_full", 6'b111010);
        bright = 4'h4;
        lit_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            e = (pc < 4'd4) ? 6'b111010 : 6'b111111;
            tick("pwm_4", e);
            if (led[0] == 1'b0) lit_cnt++;
        end
        n_assert++;
        assert (lit_cnt == 4) else begin
            n_fail++;
            $error("FAIL pwm_4_count: observed %0d lit cycles expected 4", lit_cnt);
        end
        bright = 4'h0;
        for (int i = 0; i < 16; i++) tick("pwm_0", 6'b111111);
        bright = 4'hF;
        for (int i = 0; i < 8; i++) tick("pwm_F", 6'b111010);

        // Asynchronous reset in the middle of blinking
        mode = M_BLINK;
        tick("rb_enter", 6'b111010);
        tick("rb_lit", 6'b111010);
        sys_rst_n = 1'b0;
        pc = 4'd0;
        #1;
        expect_now("rst_async", 6'b111111);
        advance();
        advance();
        mode = M_BIN;
        sys_rst_n = 1'b1;
        tick("rst2_off", 6'b111111);
        tick("rst2_lost", 6'b111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
